// File: rtl/ram_arbiter_pkg.sv
// ram_arbiter_pkg: shared constants for the RAM arbiter and its legality checker
package ram_arbiter_pkg;
  localparam logic [1:0] MODE_BYTE = 2'b00;
  localparam logic [1:0] MODE_HALF = 2'b01;
  localparam logic [1:0] MODE_WORD = 2'b10;
  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ACCESS    = 2'd1;
  localparam logic [1:0] RESP      = 2'd2;
  localparam logic       PORT_A    = 1'b0;
  localparam logic       PORT_B    = 1'b1;
endpackage

// File: rtl/ram_access_check.sv
// ram_access_check: size/alignment legality of a RAM access
module ram_access_check
  import ram_arbiter_pkg::*;
(
  input  logic [1:0] mode_i,
  input  logic [1:0] addr_lo_i,
  output logic       ok_o
);
  assign ok_o = (mode_i == MODE_BYTE) ||
                (mode_i == MODE_HALF && !addr_lo_i[0]) ||
                (mode_i == MODE_WORD && addr_lo_i == 2'b00);
endmodule

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin two-port sequencer for the shared data RAM
module ram_arbiter
  import ram_arbiter_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [1:0]        a_mode,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_err,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [1:0]        b_mode,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_err,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [1:0]        ram_mode,
  output logic              ram_we,
  output logic              ram_sel,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [CNT_W-1:0]  a_cnt,
  output logic [CNT_W-1:0]  b_cnt
);
  logic [1:0]        state_q, state_d;
  logic              last_q, last_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [1:0]        mode_q, mode_d;
  logic              we_q, we_d, sel_q, sel_d;
  logic              a_ack_q, a_ack_d, b_ack_q, b_ack_d;
  logic              a_err_q, a_err_d, b_err_q, b_err_d;
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d, b_rdata_q, b_rdata_d;
  logic [CNT_W-1:0]  a_cnt_q, a_cnt_d, b_cnt_q, b_cnt_d;
  logic              win, ok, go, in_acc, in_resp, a_cap, b_cap, a_inc, b_inc;
  logic [1:0]        w_mode;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata, rd_val;
  logic              w_we;

  // On a tie the port that did not win last time is served
  assign win     = (a_req & b_req) ? ~last_q : b_req;
  assign w_mode  = (win == PORT_B) ? b_mode  : a_mode;
  assign w_addr  = (win == PORT_B) ? b_addr  : a_addr;
  assign w_wdata = (win == PORT_B) ? b_wdata : a_wdata;
  assign w_we    = (win == PORT_B) ? b_we    : a_we;

  ram_access_check u_check (
    .mode_i   (w_mode),
    .addr_lo_i(w_addr[1:0]),
    .ok_o     (ok)
  );

  // sel_q doubles as the registered legality flag of the access in flight
  always_comb begin
    go        = (state_q == IDLE) && (a_req || b_req);
    in_acc    = (state_q == ACCESS);
    in_resp   = (state_q == RESP);
    state_d   = go ? ACCESS : in_acc ? RESP : IDLE;
    last_d    = go ? win : last_q;
    addr_d    = go ? w_addr : addr_q;
    wdata_d   = go ? w_wdata : wdata_q;
    mode_d    = go ? w_mode : mode_q;
    sel_d     = go & ok;
    we_d      = go & ok & w_we;
    rd_val    = (sel_q & ~we_q) ? ram_rdata : '0;
    a_cap     = in_acc & (last_q == PORT_A);
    b_cap     = in_acc & (last_q == PORT_B);
    a_rdata_d = a_cap ? rd_val : a_rdata_q;
    b_rdata_d = b_cap ? rd_val : b_rdata_q;
    a_err_d   = a_cap ? ~sel_q : a_err_q;
    b_err_d   = b_cap ? ~sel_q : b_err_q;
    a_ack_d   = a_cap;
    b_ack_d   = b_cap;
    a_inc     = in_resp & (last_q == PORT_A) & ~a_err_q & ~&a_cnt_q;
    b_inc     = in_resp & (last_q == PORT_B) & ~b_err_q & ~&b_cnt_q;
    a_cnt_d   = a_cnt_q + CNT_W'(a_inc);
    b_cnt_d   = b_cnt_q + CNT_W'(b_inc);
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q   <= IDLE;
      last_q    <= PORT_B;
      addr_q    <= '0;
      wdata_q   <= '0;
      mode_q    <= '0;
      we_q      <= 1'b0;
      sel_q     <= 1'b0;
      a_ack_q   <= 1'b0;
      b_ack_q   <= 1'b0;
      a_err_q   <= 1'b0;
      b_err_q   <= 1'b0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      a_cnt_q   <= '0;
      b_cnt_q   <= '0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      mode_q    <= mode_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      a_ack_q   <= a_ack_d;
      b_ack_q   <= b_ack_d;
      a_err_q   <= a_err_d;
      b_err_q   <= b_err_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      a_cnt_q   <= a_cnt_d;
      b_cnt_q   <= b_cnt_d;
    end
  end

  assign ram_addr  = addr_q;
  assign ram_wdata = wdata_q;
  assign ram_mode  = mode_q;
  assign ram_we    = we_q;
  assign ram_sel   = sel_q;
  assign a_ack     = a_ack_q;
  assign b_ack     = b_ack_q;
  assign a_err     = a_err_q;
  assign b_err     = b_err_q;
  assign a_rdata   = a_rdata_q;
  assign b_rdata   = b_rdata_q;
  assign a_cnt     = a_cnt_q;
  assign b_cnt     = b_cnt_q;
endmodule

// File: tb/tb_ram_arbiter.sv
// tb_ram_arbiter: random two-port traffic against a byte-level reference model, plus directed cases
module tb_ram_arbiter;
  logic        clk = 1'b0;
  logic        clr;
  logic [1:0]  rq, wq, ack, err;
  logic [1:0]  md [2];
  logic [11:0] ad [2];
  logic [31:0] wd [2];
  logic [31:0] rd [2];
  logic [15:0] cnt [2];
  logic [11:0] ram_addr;
  logic [31:0] ram_wdata, ram_rdata, rw, rsh;
  logic [1:0]  ram_mode;
  logic        ram_we, ram_sel;
  logic [31:0] mem [1024];
  logic [7:0]  sh [4096];
  int          nchk = 0;
  int          nerr = 0;

  always #5 clk = ~clk;

  ram_arbiter dut (
    .clk(clk), .clr(clr),
    .a_req(rq[0]), .a_we(wq[0]), .a_mode(md[0]), .a_addr(ad[0]), .a_wdata(wd[0]),
    .a_ack(ack[0]), .a_rdata(rd[0]), .a_err(err[0]),
    .b_req(rq[1]), .b_we(wq[1]), .b_mode(md[1]), .b_addr(ad[1]), .b_wdata(wd[1]),
    .b_ack(ack[1]), .b_rdata(rd[1]), .b_err(err[1]),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_mode(ram_mode), .ram_we(ram_we),
    .ram_sel(ram_sel), .ram_rdata(ram_rdata), .a_cnt(cnt[0]), .b_cnt(cnt[1])
  );

  // RAM instance stand-in: combinational zero-extended read, write on the rising edge
  always_comb begin
    rw        = mem[ram_addr[11:2]];
    rsh       = rw >> {ram_addr[1:0], 3'b000};
    ram_rdata = ram_mode == 2'b00 ? {24'b0, rsh[7:0]} : ram_mode == 2'b01 ? {16'b0, rsh[15:0]} : rw;
  end

  always @(posedge clk)
    if (ram_sel && ram_we)
      case (ram_mode)
        2'b00:   mem[ram_addr[11:2]][{ram_addr[1:0], 3'b000} +: 8] = ram_wdata[7:0];
        2'b01:   mem[ram_addr[11:2]][{ram_addr[1], 4'b0000} +: 16] = ram_wdata[15:0];
        default: mem[ram_addr[11:2]] = ram_wdata;
      endcase

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic legal(logic [1:0] m, logic [11:0] a);
    int sz = 1 << m;
    return m != 2'b11 && (int'(a) % sz) == 0;
  endfunction

  function automatic logic [31:0] sh_read(logic [1:0] m, logic [11:0] a);
    logic [31:0] v = '0;
    for (int i = 0; i < (1 << m); i++) v |= 32'(sh[int'(a) + i]) << (8 * i);
    return v;
  endfunction

  task automatic sh_write(logic [1:0] m, logic [11:0] a, logic [31:0] d);
    for (int i = 0; i < (1 << m); i++) sh[int'(a) + i] = d[8*i +: 8];
  endtask

  task automatic pulse_rst();
    clr = 1'b1;
    repeat (2) @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic txn(input int p, input logic w, input logic [1:0] m, input logic [11:0] a,
                     input logic [31:0] d, output logic [31:0] r, output logic e,
                     output int lat, output int nsel, output int nwe);
    rq[p] = 1'b1; wq[p] = w; md[p] = m; ad[p] = a; wd[p] = d;
    lat = 0; nsel = 0; nwe = 0;
    do begin
      @(negedge clk);
      lat++;
      nsel += int'(ram_sel);
      nwe  += int'(ram_we);
    end while (!ack[p] && lat < 10);
    r = rd[p];
    e = err[p];
    rq[p] = 1'b0;
    @(negedge clk);
    nsel += int'(ram_sel);
    nwe  += int'(ram_we);
  endtask

  initial begin
    logic [31:0] r, xr;
    logic        e, xw, ok, last;
    logic [1:0]  h0, h1, pend;
    int          lat, ns, nw, cyc, na, nb;
    int          wt [2];
    int          mc [2];
    int          seq [$];
    int          tm [$];
    rq = '0; wq = '0; clr = 1'b1;
    for (int p = 0; p < 2; p++) begin md[p] = '0; ad[p] = '0; wd[p] = '0; end
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    for (int i = 0; i < 4096; i++) sh[i] = '0;
    repeat (2) @(negedge clk);
    check("rst_ack", ack, 0);
    check("rst_sel_we", {ram_sel, ram_we}, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_rdata", rd[0] | rd[1], 0);
    check("rst_cnt", {cnt[1], cnt[0]}, 0);
    clr = 1'b0;

    h0 = '0; h1 = '0; pend = '0; last = 1'b1;
    wt = '{0, 0}; mc = '{0, 0};
    repeat (600) begin
      @(negedge clk);
      check("we_needs_sel", ram_we & ~ram_sel, 0);
      check("one_ack", &ack, 0);
      for (int p = 0; p < 2; p++) begin
        check(p ? "b_cnt" : "a_cnt", cnt[p], mc[p]);
        if (pend[p]) begin
          wt[p]++;
          check("wait_bound", wt[p] <= 5, 1);
        end
        if (ack[p]) begin
          xw = (h1[0] & h1[1]) ? ~last : h1[1];
          check("grant", p, xw);
          last = p[0];
          ok = legal(md[p], ad[p]);
          xr = (ok && !wq[p]) ? sh_read(md[p], ad[p]) : '0;
          if (ok && wq[p]) sh_write(md[p], ad[p], wd[p]);
          if (ok) mc[p]++;
          check("rnd_rdata", rd[p], xr);
          check("rnd_err", err[p], !ok);
          pend[p] = 1'b0;
          rq[p] = 1'b0;
        end else if (!pend[p] && $urandom_range(0, 2) != 0) begin
          pend[p] = 1'b1;
          wt[p] = 0;
          rq[p] = 1'b1;
          wq[p] = 1'($urandom_range(0, 1));
          md[p] = $urandom_range(0, 7) == 0 ? 2'b11 : 2'($urandom_range(0, 2));
          ad[p] = 12'h100 + 12'($urandom_range(0, 15));
          wd[p] = $urandom;
        end
      end
      h1 = h0;
      h0 = rq;
    end
    rq = '0;
    pulse_rst();
    check("rst2_cnt", {cnt[1], cnt[0]}, 0);

    txn(0, 1'b1, 2'b10, 12'h010, 32'hDEADBEEF, r, e, lat, ns, nw);
    check("wr_lat", lat, 2);
    check("wr_sel_cycles", ns, 1);
    check("wr_we_cycles", nw, 1);
    check("wr_err", e, 0);
    txn(0, 1'b0, 2'b10, 12'h010, 32'h0, r, e, lat, ns, nw);
    check("rd_lat", lat, 2);
    check("rd_data", r, 32'hDEADBEEF);
    check("rd_err", e, 0);
    check("rd_we_cycles", nw, 0);
    check("a_cnt_2", cnt[0], 2);

    pulse_rst();
    rq = 2'b11; wq = 2'b00;
    md[0] = 2'b10; md[1] = 2'b10; ad[0] = 12'h010; ad[1] = 12'h010;
    cyc = 0; na = 0; nb = 0;
    while (seq.size() < 4 && cyc < 30) begin
      @(negedge clk);
      cyc++;
      for (int p = 0; p < 2; p++)
        if (ack[p]) begin
          seq.push_back(p);
          tm.push_back(cyc);
          check("rr_rdata", rd[p], 32'hDEADBEEF);
          if (p == 0 && ++na == 2) rq[0] = 1'b0;
          if (p == 1 && ++nb == 2) rq[1] = 1'b0;
        end
    end
    rq = '0;
    check("rr_count", seq.size(), 4);
    for (int i = 0; i < seq.size(); i++) begin
      check("rr_order", seq[i], i % 2);
      check("rr_time", tm[i], 2 + 3 * i);
    end
    @(negedge clk);
    check("rr_cnts", {cnt[1], cnt[0]}, {16'd2, 16'd2});

    txn(1, 1'b1, 2'b01, 12'h013, 32'h1234, r, e, lat, ns, nw);
    check("ill_half_sel", ns, 0);
    check("ill_half_err", e, 1);
    check("ill_half_rdata", r, 0);
    check("ill_half_lat", lat, 2);
    txn(1, 1'b1, 2'b11, 12'h010, 32'h0, r, e, lat, ns, nw);
    check("ill_mode_sel", ns + nw, 0);
    check("ill_mode_err", e, 1);
    check("ill_mode_rdata", r, 0);
    check("ill_b_cnt", cnt[1], 2);
    txn(0, 1'b0, 2'b10, 12'h010, 32'h0, r, e, lat, ns, nw);
    check("ill_mem_kept", r, 32'hDEADBEEF);

    txn(0, 1'b1, 2'b10, 12'h020, 32'hDEADBEEF, r, e, lat, ns, nw);
    txn(1, 1'b1, 2'b00, 12'h022, 32'h00000055, r, e, lat, ns, nw);
    txn(0, 1'b0, 2'b10, 12'h020, 32'h0, r, e, lat, ns, nw);
    check("sub_word", r, 32'hDE55BEEF);
    txn(1, 1'b0, 2'b00, 12'h023, 32'h0, r, e, lat, ns, nw);
    check("sub_byte", r, 32'h000000DE);
    txn(0, 1'b0, 2'b01, 12'h022, 32'h0, r, e, lat, ns, nw);
    check("sub_half", r, 32'h0000DE55);
    check("sub_half_err", e, 0);

    rq[0] = 1'b1; wq[0] = 1'b1; md[0] = 2'b10; ad[0] = 12'h030; wd[0] = 32'h12345678;
    @(negedge clk);
    check("mid_sel_before", ram_sel, 1);
    clr = 1'b1;
    rq[0] = 1'b0;
    @(negedge clk);
    check("mid_sel_after", {ram_sel, ram_we}, 0);
    check("mid_ack", ack, 0);
    check("mid_cnt", {cnt[1], cnt[0]}, 0);
    clr = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check("mid_no_ack", ack, 0);
    end
    txn(0, 1'b0, 2'b10, 12'h010, 32'h0, r, e, lat, ns, nw);
    check("mid_next_lat", lat, 2);
    check("mid_next_data", r, 32'hDEADBEEF);
    check("mid_next_cnt", cnt[0], 1);

    force dut.a_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.a_cnt_q;
    check("sat_preset", cnt[0], 16'hFFFF);
    txn(0, 1'b0, 2'b10, 12'h010, 32'h0, r, e, lat, ns, nw);
    check("sat_err", e, 0);
    check("sat_hold", cnt[0], 16'hFFFF);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/ram_arbiter.md
Name: ram_arbiter

Overview:
Two-requester round-robin arbiter and sequencer for the shared 32-bit data RAM. Port A is the CPU load/store path and port B is the debug/loader path. The block serialises requests, checks alignment, drives the RAM select, write-enable, mode and address lines from registers, and returns read data with a one-cycle acknowledge. It sits between the datapath/debug logic and the RAM instance.

Parameters:
ADDR_W, 12, byte address width (RAM word index = addr[ADDR_W-1:2])
DATA_W, 32, data width
CNT_W, 16, width of per-port saturating grant counters

Ports:
clk  in  1  system clock; all state updates on rising edge
clr  in  1  reset, synchronous, active-high
a_req  in  1  port A request; held until a_ack
a_we  in  1  port A write (1) / read (0)
a_mode  in  2  port A size: 00 byte, 01 halfword, 10 word, 11 illegal
a_addr  in  ADDR_W  port A byte address
a_wdata  in  DATA_W  port A write data, right-aligned
a_ack  out  1  one-cycle completion pulse
a_rdata  out  DATA_W  read data, valid while a_ack=1
a_err  out  1  alignment/mode error, valid while a_ack=1
b_req, b_we, b_mode, b_addr, b_wdata, b_ack, b_rdata, b_err  same as port A
ram_addr  out  ADDR_W  to RAM Addr
ram_wdata  out  DATA_W  to RAM data_in
ram_mode  out  2  to RAM Mode
ram_we  out  1  to RAM memWrite
ram_sel  out  1  to RAM sel
ram_rdata  in  DATA_W  from RAM data_out (combinational read, already zero-extended per mode)
a_cnt, b_cnt  out  CNT_W  completed non-error transactions per port

Behaviour:
- Reset: all outputs are 0, state = IDLE, last_grant = B (so A wins the first tie), counters = 0. Reset mid-transaction aborts it: no ack is issued, and ram_sel/ram_we are 0 from the next cycle.
- FSM has three states: IDLE, ACCESS, RESP.
- IDLE, no req: stay. ram_sel = 0, ram_we = 0.
- IDLE, any req: pick the winner. If only one port requests, it wins. If both request, the port not equal to last_grant wins. Register into RAM-side registers:
  - the winner's addr, wdata, mode;
  - we = winner_we & ok;
  - sel = ok, where ok = legal access.
  - Set last_grant = winner and go to ACCESS.
- Legality:
  - mode 11 is illegal;
  - mode 01 with addr[0]=1 is illegal;
  - mode 10 with addr[1:0]≠00 is illegal;
  - mode 00 is always legal.
- ACCESS (exactly 1 cycle): RAM lines are stable. The RAM write commits at the closing edge. Capture ram_rdata into the winner's rdata register if the access is a legal read; otherwise capture 0. Set err = !ok. Go to RESP.
- RESP (exactly 1 cycle): winner ack = 1 with rdata/err held. ram_sel = 0, ram_we = 0. Increment the winner's counter if !err, saturating at all-ones. Always return to IDLE; no request is sampled in RESP.
- Timing: latency is req seen in IDLE at edge N, ack high in cycle N+2. Throughput is at most one transaction every 3 cycles.
- Requester rules:
  - A requester keeps req and its fields stable until the ack cycle.
  - It may deassert req, or present a new transaction, in the cycle after ack.
  - The arbiter samples fields only in IDLE.
- rdata and err of the non-winning port keep their last value; ack is only meaningful when 1.
- Simultaneous requests alternate strictly, e.g. A, B, A, B… while both are held. A single continuous requester is served every 3 cycles with no idle gap imposed by the other port.
- ram_we is never 1 unless ram_sel is 1.

Decomposition:
- Shared package holds:
  - mode constants MODE_BYTE = 2'b00, MODE_HALF = 2'b01, MODE_WORD = 2'b10;
  - state encoding IDLE/ACCESS/RESP;
  - port-id constants PORT_A/PORT_B.
- One natural sub-module is ram_access_check: combinational mode/addr legality, shared by both ports.
- Counters stay inline.

Test Plan:
- Reset, then A word write to addr 0x010 with data 0xDEADBEEF, then A word read of 0x010:
  - ram_sel=1 and ram_we=1 for exactly one cycle on the write;
  - the read's a_ack arrives 2 cycles after the IDLE sample, with a_rdata = 0xDEADBEEF and a_err = 0;
  - a_cnt = 2.
- A and B both request reads in the same cycle, both held for 4 transactions:
  - grant order is A, B, A, B;
  - each ack arrives 3 cycles after the previous one.
- Illegal accesses, B halfword write to 0x013 and B mode 11:
  - ram_sel stays 0 throughout;
  - b_ack = 1 with b_err = 1 and b_rdata = 0;
  - b_cnt unchanged;
  - memory at 0x010 is unchanged on readback.
- Sub-word accesses:
  - write 0xDEADBEEF to 0x020, byte write 0x55 to 0x022, word read of 0x020 → 0xDE55BEEF;
  - byte read of 0x023 → 0x000000DE;
  - halfword read of 0x022 → 0x0000DE55.
- Reset mid-operation:
  - assert clr during ACCESS of an A write → no a_ack;
  - ram_sel = 0 next cycle;
  - counters = 0;
  - the next A request completes normally.
- Counter saturation: force a_cnt to 0xFFFF, perform a legal access → a_cnt stays 0xFFFF.
